// File: rtl/backtrack_unit_pkg.sv
// Shared solver definitions: variable sizing and the trace-table entry layout.
`include "sysdefs.svh"

package backtrack_unit_pkg;

  localparam int unsigned MAX_VARS      = `MAX_VARS;
  localparam int unsigned MAX_VARS_BITS = `MAX_VARS_BITS;

  localparam logic TR_DECIDE = 1'b0;
  localparam logic TR_FORCED = 1'b1;

  typedef struct packed {
    logic                     typ;
    logic                     val;
    logic [MAX_VARS_BITS-1:0] var_idx;
  } trace_entry_t;

endpackage

// File: rtl/sysdefs.svh
// System-wide sizing for the solver datapath: number of variables and index width.
`ifndef SYSDEFS_SVH
`define SYSDEFS_SVH
`define MAX_VARS      64
`define MAX_VARS_BITS 6
`endif

// File: rtl/backtrack_unit.sv
// Conflict backtrack engine: unwinds the trace table to the newest decision and flips it.
// Optional BACKTRACK_STATS_EN adds bt_count / bt_depth statistics outputs.
module backtrack_unit
  import backtrack_unit_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     tr_type,
  input  logic                     tr_val,
  input  logic [MAX_VARS_BITS-1:0] tr_var,
  input  logic                     tr_empty,
  output logic                     tr_pop,
  output logic                     tr_push,
  output logic                     tr_type_o,
  output logic                     tr_val_o,
  output logic [MAX_VARS_BITS-1:0] tr_var_o,
  output logic                     va_we,
  output logic [MAX_VARS_BITS-1:0] va_var,
  output logic                     va_assigned,
  output logic                     va_val,
  output logic                     busy,
  output logic                     done,
`ifdef BACKTRACK_STATS_EN
  output logic                     unsat,
  output logic [15:0]              bt_count,
  output logic [MAX_VARS_BITS:0]   bt_depth
`else
  output logic                     unsat
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_FLIP,
    S_DONE,
    S_UNSAT
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;
  logic         w_capture;
  trace_entry_t r_flip;
  logic         r_done;
  logic         r_unsat;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and strobes; trace-table and assignment strobes are decoded from state and inputs
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    tr_pop      = 1'b0;
    tr_push     = 1'b0;
    tr_type_o   = 1'b0;
    tr_val_o    = 1'b0;
    tr_var_o    = '0;
    va_we       = 1'b0;
    va_var      = '0;
    va_assigned = 1'b0;
    va_val      = 1'b0;
    busy        = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        if (tr_empty) begin
          w_state_nxt = S_UNSAT;
        end else begin
          tr_pop = 1'b1;
          va_we  = 1'b1;
          va_var = tr_var;
          if (tr_type == TR_DECIDE) begin
            w_capture   = 1'b1;
            w_state_nxt = S_FLIP;
          end
        end
      end
      S_FLIP: begin
        tr_push     = 1'b1;
        tr_type_o   = r_flip.typ;
        tr_val_o    = r_flip.val;
        tr_var_o    = r_flip.var_idx;
        va_we       = 1'b1;
        va_assigned = 1'b1;
        va_val      = r_flip.val;
        va_var      = r_flip.var_idx;
        w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      S_UNSAT: begin
        w_state_nxt = S_UNSAT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Flipped decision is re-pushed as a forced entry with the opposite value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_flip  <= '0;
      r_done  <= 1'b0;
      r_unsat <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLIP);
      if (w_capture) begin
        r_flip <= '{typ: TR_FORCED, val: ~tr_val, var_idx: tr_var};
      end
      if (w_state_nxt == S_UNSAT) begin
        r_unsat <= 1'b1;
      end
    end
  end

  assign done  = r_done;
  assign unsat = r_unsat;

`ifdef BACKTRACK_STATS_EN
  localparam int unsigned DEPTH_W = MAX_VARS_BITS + 1;
  localparam int unsigned CNT_W   = 16;

  logic [DEPTH_W-1:0] r_pop_cnt;
  logic [DEPTH_W-1:0] r_bt_depth;
  logic [CNT_W-1:0]   r_bt_count;

  // Per-backtrack pop count, latched as depth when the backtrack resolves
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pop_cnt  <= '0;
      r_bt_depth <= '0;
      r_bt_count <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_pop_cnt <= '0;
      end else if (tr_pop) begin
        r_pop_cnt <= r_pop_cnt + DEPTH_W'(1);
      end
      if (r_state == S_DONE) begin
        r_bt_depth <= r_pop_cnt;
        if (r_bt_count != {CNT_W{1'b1}}) begin
          r_bt_count <= r_bt_count + CNT_W'(1);
        end
      end else if ((r_state == S_POP) && tr_empty) begin
        r_bt_depth <= r_pop_cnt;
      end
    end
  end

  assign bt_count = r_bt_count;
  assign bt_depth = r_bt_depth;
`endif

endmodule

// File: tb/tb_backtrack_unit.sv
// Self-checking bench for backtrack_unit with a behavioural trace-table stack and event scoreboard.
module tb_backtrack_unit;
  import backtrack_unit_pkg::*;

  localparam int unsigned VB = MAX_VARS_BITS;

  typedef struct {
    int          cyc;
    bit          push;
    bit          assigned;
    bit          val;
    logic [VB-1:0] v;
  } ev_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic          tr_type;
  logic          tr_val;
  logic [VB-1:0] tr_var;
  logic          tr_empty;
  logic          tr_pop;
  logic          tr_push;
  logic          tr_type_o;
  logic          tr_val_o;
  logic [VB-1:0] tr_var_o;
  logic          va_we;
  logic [VB-1:0] va_var;
  logic          va_assigned;
  logic          va_val;
  logic          busy;
  logic          done;
  logic          unsat;
`ifdef BACKTRACK_STATS_EN
  logic [15:0]   bt_count;
  logic [VB:0]   bt_depth;
`endif

  trace_entry_t stk[$];
  ev_t          exp_q[$];
  int           checks;
  int           errors;
  int           exp_done;
  int           exp_unsat;
  int           exp_size;
  int           exp_depth;

  backtrack_unit u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .tr_type     (tr_type),
    .tr_val      (tr_val),
    .tr_var      (tr_var),
    .tr_empty    (tr_empty),
    .tr_pop      (tr_pop),
    .tr_push     (tr_push),
    .tr_type_o   (tr_type_o),
    .tr_val_o    (tr_val_o),
    .tr_var_o    (tr_var_o),
    .va_we       (va_we),
    .va_var      (va_var),
    .va_assigned (va_assigned),
    .va_val      (va_val),
    .busy        (busy),
    .done        (done),
`ifdef BACKTRACK_STATS_EN
    .unsat       (unsat),
    .bt_count    (bt_count),
    .bt_depth    (bt_depth)
`else
    .unsat       (unsat)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic trace_entry_t mk(input logic t, input logic v, input int unsigned idx);
    trace_entry_t e;
    e.typ     = t;
    e.val     = v;
    e.var_idx = VB'(idx);
    return e;
  endfunction

  task automatic drive_top();
    trace_entry_t e;
    if (stk.size() == 0) begin
      tr_empty = 1'b1;
      tr_type  = 1'b0;
      tr_val   = 1'b0;
      tr_var   = '0;
    end else begin
      e        = stk[$];
      tr_empty = 1'b0;
      tr_type  = e.typ;
      tr_val   = e.val;
      tr_var   = e.var_idx;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    start = 1'b0;
    stk.delete();
    drive_top();
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  // Expected unassign/flip events derived from the current stack contents
  task automatic build_expect();
    int  n;
    bit  hit;
    int  sz;
    ev_t e;
    n   = 0;
    hit = 0;
    sz  = stk.size();
    exp_q.delete();
    exp_done  = 0;
    exp_unsat = 0;
    for (int k = sz - 1; k >= 0 && !hit; k--) begin
      e.cyc = 2 + n; e.push = 0; e.assigned = 0; e.val = 0; e.v = stk[k].var_idx;
      exp_q.push_back(e);
      n++;
      if (stk[k].typ == 1'b0) begin
        hit = 1;
        e.cyc = 2 + n; e.push = 1; e.assigned = 1; e.val = ~stk[k].val;
        exp_q.push_back(e);
      end
    end
    if (hit) begin
      exp_done = 3 + n;
      exp_size = sz - n + 1;
    end else begin
      exp_unsat = 3 + n;
      exp_size  = 0;
    end
    exp_depth = n;
  endtask

  // Start in cycle 1 and track the DUT until done or unsat; restart_cyc re-pulses start while busy
  task automatic run_bt(input int restart_cyc, output int done_cyc, output int unsat_cyc);
    int           cyc;
    bit           fin;
    bit           pop_seen;
    bit           push_seen;
    trace_entry_t pe;
    ev_t          e;
    build_expect();
    @(posedge clock);
    #1;
    start     = 1'b1;
    cyc       = 1;
    fin       = 0;
    done_cyc  = 0;
    unsat_cyc = 0;
    while (!fin && cyc <= 40) begin
      @(negedge clock);
      checks++;
      if (busy !== (cyc >= 2)) begin
        errors++; $display("FAIL busy cyc %0d: got %b want %b", cyc, busy, (cyc >= 2));
      end
      checks++;
      if (tr_pop === 1'b1 && tr_push === 1'b1) begin
        errors++; $display("FAIL pop_push_overlap cyc %0d: got both high want exclusive", cyc);
      end
      if (va_we === 1'b1 || tr_push === 1'b1 || tr_pop === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc %0d: got we=%b pop=%b push=%b want none", cyc, va_we, tr_pop, tr_push);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (cyc != e.cyc) begin
            errors++; $display("FAIL event_cycle: got %0d want %0d", cyc, e.cyc);
          end
          checks++;
          if (va_we !== 1'b1 || va_assigned !== e.assigned || va_var !== e.v ||
              tr_push !== e.push || tr_pop !== ~e.push) begin
            errors++;
            $display("FAIL event_fields cyc %0d: got we=%b asg=%b var=%0d push=%b pop=%b want we=1 asg=%b var=%0d push=%b pop=%b",
                     cyc, va_we, va_assigned, va_var, tr_push, tr_pop, e.assigned, e.v, e.push, ~e.push);
          end
          if (e.push) begin
            checks++;
            if (tr_type_o !== 1'b1 || tr_val_o !== e.val || tr_var_o !== e.v || va_val !== e.val) begin
              errors++;
              $display("FAIL push_entry cyc %0d: got type=%b val=%b var=%0d va_val=%b want type=1 val=%b var=%0d",
                       cyc, tr_type_o, tr_val_o, tr_var_o, va_val, e.val, e.v);
            end
          end
        end
      end
      if (done === 1'b1) begin done_cyc = cyc; fin = 1; end
      if (unsat === 1'b1) begin unsat_cyc = cyc; fin = 1; end
      pop_seen  = (tr_pop === 1'b1);
      push_seen = (tr_push === 1'b1);
      pe = '{typ: tr_type_o, val: tr_val_o, var_idx: tr_var_o};
      @(posedge clock);
      #1;
      start = (cyc + 1 == restart_cyc);
      if (pop_seen && stk.size() > 0) void'(stk.pop_back());
      if (push_seen) stk.push_back(pe);
      drive_top();
      cyc++;
    end
    start = 1'b0;
    checks++;
    if (!fin) begin
      errors++; $display("FAIL timeout: got no done/unsat within 40 cycles want termination");
    end
    checks++;
    if (done_cyc != exp_done) begin
      errors++; $display("FAIL done_cycle: got %0d want %0d", done_cyc, exp_done);
    end
    checks++;
    if (unsat_cyc != exp_unsat) begin
      errors++; $display("FAIL unsat_cycle: got %0d want %0d", unsat_cyc, exp_unsat);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL missing_events: got %0d left want 0", exp_q.size());
    end
    checks++;
    if (stk.size() != exp_size) begin
      errors++; $display("FAIL trace_depth: got %0d want %0d", stk.size(), exp_size);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks++;
    if ({tr_pop, tr_push, va_we, busy, done, unsat} !== 6'b0) begin
      errors++;
      $display("FAIL %s: got pop=%b push=%b we=%b busy=%b done=%b unsat=%b want all 0",
               tag, tr_pop, tr_push, va_we, busy, done, unsat);
    end
  endtask

  task automatic check_after_done();
    @(negedge clock);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse_end: got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    check_idle_outputs("reset_state");
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_flip_multi();
    int d, u;
    trace_entry_t top;
    stk.delete();
    stk.push_back(mk(1'b0, 1'b1, 3));
    stk.push_back(mk(1'b1, 1'b0, 5));
    stk.push_back(mk(1'b1, 1'b1, 7));
    drive_top();
    run_bt(0, d, u);
    checks++;
    if (d != 6) begin
      errors++; $display("FAIL multi_done_at_6: got %0d want 6", d);
    end
    top = (stk.size() > 0) ? stk[$] : '0;
    checks++;
    if (top !== mk(1'b1, 1'b0, 3)) begin
      errors++; $display("FAIL multi_pushed: got %h want %h", top, mk(1'b1, 1'b0, 3));
    end
    check_after_done();
  endtask

  task automatic test_flip_single();
    int d, u;
    stk.delete();
    stk.push_back(mk(1'b0, 1'b0, 1));
    drive_top();
    run_bt(0, d, u);
    checks++;
    if (d != 4) begin
      errors++; $display("FAIL single_done_at_4: got %0d want 4", d);
    end
    check_after_done();
  endtask

`ifdef BACKTRACK_STATS_EN
  task automatic test_stats();
    checks++;
    if (bt_count !== 16'd2 || bt_depth !== (VB + 1)'(1)) begin
      errors++; $display("FAIL stats: got count=%0d depth=%0d want 2 1", bt_count, bt_depth);
    end
  endtask
`endif

  task automatic test_back_to_back();
    int d, u;
    stk.delete();
    stk.push_back(mk(1'b0, 1'b1, 20));
    stk.push_back(mk(1'b0, 1'b0, 10));
    stk.push_back(mk(1'b1, 1'b1, 11));
    stk.push_back(mk(1'b1, 1'b1, 12));
    stk.push_back(mk(1'b1, 1'b0, 13));
    drive_top();
    run_bt(3, d, u);
    checks++;
    if (d != 7) begin
      errors++; $display("FAIL b2b_first_done: got %0d want 7", d);
    end
    run_bt(0, d, u);
    checks++;
    if (d != 5) begin
      errors++; $display("FAIL b2b_second_done: got %0d want 5", d);
    end
    check_after_done();
  endtask

  task automatic test_unsat_forced();
    int d, u;
    stk.delete();
    stk.push_back(mk(1'b1, 1'b1, 2));
    stk.push_back(mk(1'b1, 1'b0, 4));
    drive_top();
    run_bt(0, d, u);
    checks++;
    if (u != 5) begin
      errors++; $display("FAIL unsat_forced_cycle: got %0d want 5", u);
    end
    stk.push_back(mk(1'b0, 1'b1, 9));
    drive_top();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    repeat (4) begin
      @(negedge clock);
      checks++;
      if (unsat !== 1'b1 || busy !== 1'b1 || va_we !== 1'b0 || tr_pop !== 1'b0 || tr_push !== 1'b0) begin
        errors++;
        $display("FAIL unsat_sticky: got unsat=%b busy=%b we=%b pop=%b push=%b want 1 1 0 0 0",
                 unsat, busy, va_we, tr_pop, tr_push);
      end
    end
  endtask

  task automatic test_unsat_empty();
    int d, u;
    do_reset();
    run_bt(0, d, u);
    checks++;
    if (u != 3) begin
      errors++; $display("FAIL unsat_empty_cycle: got %0d want 3", u);
    end
  endtask

  task automatic test_reset_mid_pop();
    int d, u;
    do_reset();
    stk.push_back(mk(1'b0, 1'b1, 3));
    stk.push_back(mk(1'b1, 1'b0, 5));
    stk.push_back(mk(1'b1, 1'b1, 7));
    drive_top();
    @(posedge clock); #1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    #1;
    checks++;
    if (tr_pop !== 1'b1 || va_we !== 1'b1) begin
      errors++; $display("FAIL mid_pop_active: got pop=%b we=%b want 1 1", tr_pop, va_we);
    end
    reset = 1'b0;
    #1;
    check_idle_outputs("async_reset_mid_pop");
    stk.delete();
    drive_top();
    repeat (2) @(negedge clock);
    check_idle_outputs("held_reset");
    reset = 1'b1;
    stk.push_back(mk(1'b0, 1'b1, 3));
    stk.push_back(mk(1'b1, 1'b0, 5));
    stk.push_back(mk(1'b1, 1'b1, 7));
    drive_top();
    run_bt(0, d, u);
    checks++;
    if (d != 6) begin
      errors++; $display("FAIL post_reset_done_at_6: got %0d want 6", d);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    start  = 1'b0;
    stk.delete();
    drive_top();
    test_reset();
    test_flip_multi();
    test_flip_single();
`ifdef BACKTRACK_STATS_EN
    test_stats();
`endif
    test_back_to_back();
    test_unsat_forced();
    test_unsat_empty();
    test_reset_mid_pop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/backtrack_unit.md
BACKTRACK_UNIT -- requirements
Module: backtrack_unit

Interface
REQ-001 SHALL have ports, clock and reset first:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to backtrack after a conflict; ignored unless idle.
- tr_type  in  1  trace-table top type (0 decide, 1 forced); valid combinationally while tr_pop=1 and tr_empty=0.
- tr_val  in  1  trace-table top value.
- tr_var  in  MAX_VARS_BITS  trace-table top variable index.
- tr_empty  in  1  trace-table empty flag.
- tr_pop  out  1  pop request to trace table.
- tr_push  out  1  push request to trace table.
- tr_type_o  out  1  pushed type.
- tr_val_o  out  1  pushed value.
- tr_var_o  out  MAX_VARS_BITS  pushed variable.
- va_we  out  1  variable-assignment write strobe.
- va_var  out  MAX_VARS_BITS  variable being written.
- va_assigned  out  1  0 = unassign, 1 = assign.
- va_val  out  1  value written when va_assigned=1.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse when a decision was flipped.
- unsat  out  1  sticky; trace exhausted with no decision left.

Function
REQ-002 SHALL implement FSM states IDLE, POP, FLIP, DONE, UNSAT.
REQ-003 IDLE: start=1 SHALL move to POP next cycle; all strobes low.
REQ-004 POP: SHALL assert tr_pop every cycle; if tr_empty=1, SHALL deassert tr_pop that cycle and go to UNSAT.
REQ-005 POP with tr_empty=0: SHALL assert va_we, va_assigned=0, va_var=tr_var the same cycle (unassign of popped entry).
REQ-006 POP with tr_type=1: SHALL stay in POP; one entry consumed per cycle.
REQ-007 POP with tr_type=0: SHALL register tr_var and ~tr_val and go to FLIP.
REQ-008 FLIP: SHALL assert tr_push with tr_type_o=1, tr_val_o=registered ~val, tr_var_o=registered var, and simultaneously va_we=1, va_assigned=1, va_val/va_var equal to the pushed values; tr_pop=0.
REQ-009 FLIP SHALL last exactly one cycle, then DONE; DONE SHALL pulse done=1 for one cycle, then IDLE.
REQ-010 tr_push and tr_pop SHALL never be high in the same cycle.
REQ-011 Latency: start to done = N+3 cycles, N = entries popped (including the decision).
REQ-012 UNSAT SHALL hold unsat=1, busy=1 and ignore start until reset.
REQ-013 start while busy SHALL be ignored without side effect.
REQ-014 All outputs other than done/unsat SHALL be combinational from state plus inputs; no trace-table full check is needed because FLIP follows at least one pop.

Reset
REQ-015 reset=0 SHALL asynchronously force IDLE, registered var/val to 0, unsat=0, done=0; all strobes 0, including mid-pop or mid-flip.
REQ-016 Release of reset SHALL be sampled on the next rising clock; trace-table consistency after mid-operation reset is the caller's responsibility (trace table reset together).

Configuration
REQ-017 Macro BACKTRACK_STATS_EN: when defined, SHALL add outputs bt_count (16 bits, completed backtracks, saturating) and bt_depth (MAX_VARS_BITS+1 bits, entries popped in last backtrack, updated at DONE or UNSAT), both reset to 0; when undefined, these ports and counters SHALL not exist and behaviour is otherwise identical.

Structure
REQ-018 MAX_VARS and MAX_VARS_BITS SHALL come from sysdefs.svh; a trace-entry struct {type, val, var} SHALL be added to the shared package; the FSM state enum SHALL remain local.
REQ-019 No sub-module; the trace table is instantiated alongside, not inside.

Verification
REQ-020 Trace [D v3=1, F v5=0, F v7=1] (top last), start -> unassign v7, v5, v3 on consecutive cycles; push {F,0,v3}; assign v3=0; done at cycle 6.
REQ-021 Trace [D v1=0] only -> one unassign v1, push {F,1,v1}, done at cycle 4.
REQ-022 Trace [F v2=1, F v4=0] -> unassign v4, v2, then tr_empty -> unsat=1 sticky; later start ignored.
REQ-023 Empty trace at start -> unsat=1 after 2 cycles, no va_we.
REQ-024 Reset asserted during POP -> outputs 0 immediately (asynchronous), IDLE after release; new start behaves per REQ-020.
REQ-025 With BACKTRACK_STATS_EN, REQ-020 followed by REQ-021 -> bt_count=2, bt_depth=1.
